// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - host debug controller: gates pipeline enable, dumps a 46-byte state frame to the UART TX FIFO
module debug_unit #(
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] MAX_CYCLES = 32'd1024,
  parameter logic [7:0]  CMD_STEP   = 8'h73,
  parameter logic [7:0]  CMD_RUN    = 8'h63,
  parameter logic [7:0]  CMD_PAUSE  = 8'h70,
  parameter logic [7:0]  CMD_DUMP   = 8'h64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [321:0] debug_signal,
  input  logic [9:0]   PC_plus_1,
  input  logic [7:0]   rx_data,
  input  logic         rx_empty,
  output logic         rd,
  output logic [7:0]   tx_data,
  input  logic         tx_full,
  output logic         wr,
  output logic         pipe_enable,
  output logic         halted
);
  localparam int         FRAME_W   = 368;
  localparam logic [5:0] LAST_BYTE = 6'd45;

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_RUN, S_CAPTURE, S_SEND, S_HALTED
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_cycle_count;
  logic [31:0]        r_run_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [5:0]         r_byte_cnt;
  logic               r_halted;
  logic               w_halt_hit;
  logic               w_pause_hit;
  logic               w_limit_hit;
  logic               w_tx_go;

  assign w_halt_hit  = (debug_signal[321:290] == HALT_INSTR);
  assign w_pause_hit = !rx_empty && (rx_data == CMD_PAUSE);
  assign w_limit_hit = (r_run_cnt == MAX_CYCLES - 32'd1);
  assign w_tx_go     = (r_state == S_SEND) && !tx_full;
  assign tx_data     = r_shift[FRAME_W-1 -: 8];
  assign halted      = r_halted;

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!rx_empty) begin
          if (rx_data == CMD_STEP)      w_next = S_STEP;
          else if (rx_data == CMD_RUN)  w_next = S_RUN;
          else if (rx_data == CMD_DUMP) w_next = S_CAPTURE;
        end
      end
      S_STEP:    w_next = S_CAPTURE;
      S_RUN:     if (w_halt_hit || w_limit_hit || w_pause_hit) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (w_tx_go && r_byte_cnt == LAST_BYTE) w_next = r_halted ? S_HALTED : S_IDLE;
      S_HALTED:  if (!rx_empty && rx_data == CMD_DUMP) w_next = S_CAPTURE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes are held low while reset is asserted so no FIFO pop or pipeline step leaks through
  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    pipe_enable = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IDLE, S_HALTED: rd = !rx_empty;
        S_STEP:           pipe_enable = 1'b1;
        S_RUN: begin
          pipe_enable = 1'b1;
          rd          = w_pause_hit;
        end
        S_SEND:           wr = !tx_full;
        default:          ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
      r_run_cnt     <= '0;
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      if (r_state == S_STEP || r_state == S_RUN) r_cycle_count <= r_cycle_count + 32'd1;
      // Run-length counter is only meaningful inside RUN, so any other state rearms it
      if (r_state == S_RUN) r_run_cnt <= r_run_cnt + 32'd1;
      else                  r_run_cnt <= '0;
      if (r_state == S_RUN && w_halt_hit) r_halted <= 1'b1;
      if (r_state == S_CAPTURE) begin
        r_shift    <= {r_cycle_count, 4'b0000, PC_plus_1, debug_signal};
        r_byte_cnt <= '0;
      end else if (w_tx_go) begin
        r_shift    <= {r_shift[FRAME_W-9:0], 8'h00};
        r_byte_cnt <= r_byte_cnt + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - randomized bench for debug_unit against a frame-queue reference model
module tb_debug_unit;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          MAXC = 16;

  logic         clock;
  logic         reset_n;
  logic [321:0] debug_signal;
  logic [9:0]   PC_plus_1;
  logic [7:0]   rx_data;
  logic         rx_empty;
  logic         rd;
  logic [7:0]   tx_data;
  logic         tx_full;
  logic         wr;
  logic         pipe_enable;
  logic         halted;

  debug_unit #(.MAX_CYCLES(32'd16)) dut (
    .clock(clock), .reset_n(reset_n), .debug_signal(debug_signal), .PC_plus_1(PC_plus_1),
    .rx_data(rx_data), .rx_empty(rx_empty), .rd(rd), .tx_data(tx_data), .tx_full(tx_full),
    .wr(wr), .pipe_enable(pipe_enable), .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] rx_q[$];
  logic [7:0] got_tx[$];
  logic [7:0] saved[$];
  bit   pop_req = 0;
  int   en_cnt, rd_cnt, wr_cnt, wr_first, wr_last;

  // Reference model: pending work flags plus the list of bytes the frame must still produce
  logic [31:0] m_count;
  bit          m_halted, m_step, m_running, m_cap;
  int          m_run_len;
  logic [7:0]  m_txq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic       e_en, e_rd, e_wr, e_halt, hit_h, hit_p;
    logic [7:0] e_tx;
    logic [367:0] frame;
    cyc++;
    if (!reset_n) begin
      chk("rst_rd", rd, 0);
      chk("rst_wr", wr, 0);
      chk("rst_en", pipe_enable, 0);
      m_count = 0; m_halted = 0; m_step = 0; m_running = 0; m_cap = 0; m_run_len = 0;
      m_txq.delete();
      pop_req = 0;
    end else begin
      e_en = 0; e_rd = 0; e_wr = 0;
      e_halt = m_halted;
      e_tx = (m_txq.size() > 0) ? m_txq[0] : 8'h00;
      if (m_step) begin
        e_en = 1; m_count++; m_step = 0; m_cap = 1;
      end else if (m_running) begin
        e_en = 1; m_count++; m_run_len++;
        hit_h = (debug_signal[321:290] == HALT);
        hit_p = !rx_empty && rx_data == 8'h70;
        e_rd = hit_p;
        if (hit_h) m_halted = 1;
        if (hit_h || hit_p || m_run_len == MAXC) begin
          m_running = 0; m_cap = 1;
        end
      end else if (m_cap) begin
        frame = {m_count, 4'b0000, PC_plus_1, debug_signal};
        for (int i = 0; i < 46; i++) m_txq.push_back(frame[367 - 8*i -: 8]);
        m_cap = 0;
      end else if (m_txq.size() > 0) begin
        e_wr = !tx_full;
        if (e_wr) void'(m_txq.pop_front());
      end else if (!rx_empty) begin
        e_rd = 1;
        if (rx_data == 8'h64) m_cap = 1;
        else if (!m_halted && rx_data == 8'h73) m_step = 1;
        else if (!m_halted && rx_data == 8'h63) begin m_running = 1; m_run_len = 0; end
      end
      chk("pipe_enable", pipe_enable, e_en);
      chk("rd", rd, e_rd);
      chk("wr", wr, e_wr);
      chk("halted", halted, e_halt);
      chk("tx_data", tx_data, e_tx);
      chk("rd_wr_excl", rd & wr, 0);
      pop_req = rd;
      if (wr) begin
        got_tx.push_back(tx_data);
        wr_cnt++;
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
      end
      if (pipe_enable) en_cnt++;
      if (rd) rd_cnt++;
    end
  end

  task automatic upd_rx();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
    upd_rx();
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    upd_rx();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_q.delete();
    upd_rx();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic clr();
    got_tx.delete();
    en_cnt = 0; rd_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1;
  endtask

  task automatic drive_debug(input bit halt);
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    if (halt) t[321:290] = HALT;
    else if (t[321:290] == HALT) t[290] = 1'b0;
    debug_signal = t[321:0];
  endtask

  function automatic bit quiet();
    return !m_step && !m_running && !m_cap && m_txq.size() == 0 && rx_q.size() == 0;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!quiet() && n < budget) begin
      tick();
      n++;
    end
    chk(name, quiet(), 1);
  endtask

  task automatic chk_hdr(input string name, input logic [31:0] count);
    chk({name, "_nbytes"}, got_tx.size(), 46);
    if (got_tx.size() >= 4) chk({name, "_count"}, {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, count);
  endtask

  initial begin
    logic [367:0] ef;
    int bad;
    reset_n = 1'b0; tx_full = 1'b0; PC_plus_1 = 10'h2A7;
    drive_debug(0);
    rx_q.delete(); upd_rx(); clr();
    repeat (3) tick();
    reset_n = 1'b1;
    chk("post_reset_en", pipe_enable, 0);
    chk("post_reset_halted", halted, 0);
    chk("post_reset_tx", tx_data, 0);

    // Single step from reset
    clr(); push_rx(8'h73);
    wait_idle(200, "step_done");
    chk("step_enables", en_cnt, 1);
    chk_hdr("step", 32'd1);
    chk("step_byte4", got_tx[4], {4'b0000, PC_plus_1[9:6]});
    chk("step_wr_consecutive", wr_last - wr_first, 45);

    // Run until halt on the 10th enabled cycle
    do_reset(); clr(); push_rx(8'h63);
    tick();
    repeat (9) tick();
    drive_debug(1);
    tick();
    drive_debug(0);
    wait_idle(200, "halt_done");
    chk("halt_enables", en_cnt, 10);
    chk("halt_flag", halted, 1);
    chk_hdr("halt", 32'd10);
    saved = got_tx;
    clr(); push_rx(8'h73);
    wait_idle(50, "halted_step_drop");
    chk("halted_step_enables", en_cnt, 0);
    chk("halted_step_bytes", got_tx.size(), 0);
    clr(); push_rx(8'h64);
    wait_idle(200, "redump_done");
    bad = 0;
    for (int i = 0; i < 46; i++) if (got_tx[i] !== saved[i]) bad++;
    chk("redump_identical", bad, 0);
    chk("redump_nbytes", got_tx.size(), 46);

    // Run to the cycle limit
    do_reset(); clr(); push_rx(8'h63);
    wait_idle(300, "limit_done");
    chk("limit_enables", en_cnt, MAXC);
    chk_hdr("limit", 32'h10);
    chk("limit_not_halted", halted, 0);

    // Pause after five enabled cycles
    do_reset(); clr(); push_rx(8'h63);
    tick(); rd_cnt = 0;
    repeat (4) tick();
    push_rx(8'h70);
    wait_idle(300, "pause_done");
    chk("pause_enables", en_cnt, 5);
    chk("pause_rd_pulses", rd_cnt, 1);
    chk_hdr("pause", 32'd5);

    // Backpressure after byte 10
    do_reset(); clr(); drive_debug(0); PC_plus_1 = 10'($urandom);
    push_rx(8'h73);
    for (int n = 0; n < 100 && got_tx.size() < 10; n++) tick();
    chk("bp_reached_10", got_tx.size(), 10);
    tx_full = 1'b1;
    wr_cnt = 0;
    repeat (20) tick();
    chk("bp_no_wr_while_full", wr_cnt, 0);
    tx_full = 1'b0;
    wait_idle(200, "bp_done");
    ef = {32'd1, 4'b0000, PC_plus_1, debug_signal};
    bad = 0;
    for (int i = 0; i < 46; i++) if (got_tx[i] !== ef[367 - 8*i -: 8]) bad++;
    chk("bp_frame_exact", bad, 0);
    chk("bp_nbytes", got_tx.size(), 46);

    // Reset mid-SEND, then mid-RUN
    do_reset(); clr(); push_rx(8'h73);
    for (int n = 0; n < 100 && got_tx.size() < 20; n++) tick();
    do_reset();
    chk("rst_send_en", pipe_enable, 0);
    chk("rst_send_wr", wr, 0);
    chk("rst_send_rd", rd, 0);
    chk("rst_send_tx", tx_data, 0);
    clr(); push_rx(8'h73);
    wait_idle(200, "rst_send_step");
    chk_hdr("rst_send_step", 32'd1);
    clr(); push_rx(8'h63);
    repeat (7) tick();
    do_reset();
    chk("rst_run_en", pipe_enable, 0);
    chk("rst_run_halted", halted, 0);
    chk("rst_run_tx", tx_data, 0);
    clr(); push_rx(8'h73);
    wait_idle(200, "rst_run_step");
    chk_hdr("rst_run_step", 32'd1);

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] cmds [6];
      cmds = '{8'h73, 8'h63, 8'h64, 8'h70, 8'h70, 8'h00};
      drive_debug($urandom_range(0, 39) == 0);
      PC_plus_1 = 10'($urandom);
      tx_full = ($urandom_range(0, 3) == 0);
      if (rx_q.size() < 3 && $urandom_range(0, 9) == 0) begin
        cmds[5] = 8'($urandom);
        push_rx(cmds[$urandom_range(0, 5)]);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end
    tx_full = 1'b0;
    drive_debug(0);
    wait_idle(600, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side debug controller sitting directly downstream of the MIPS pipeline top, between it and the UART.
- Receives one-byte commands from the UART RX FIFO and gates the pipeline `enable` (run continuously or single-step).
- After each stop it captures `debug_signal`, `PC_plus_1` and a cycle counter into a fixed frame and streams it byte-by-byte into the UART TX FIFO.

Parameters:
- HALT_INSTR, 32'hFFFF_FFFF: instruction word in the IF/ID slot that stops RUN mode.
- MAX_CYCLES, 32'd1024: RUN-mode cycle limit; forced stop when reached.
- CMD_STEP, 8'h73: 's', execute one pipeline cycle then dump.
- CMD_RUN, 8'h63: 'c', run until halt, pause or limit, then dump.
- CMD_PAUSE, 8'h70: 'p', stops RUN mode and dumps.
- CMD_DUMP, 8'h64: 'd', re-dump without advancing the pipeline.

Ports:
- clock, input, 1: single system clock; all logic rising-edge.
- reset_n, input, 1: synchronous, active-low reset.
- debug_signal, input, 322: pipeline latch snapshot; bits [321:290] = IF/ID instruction.
- PC_plus_1, input, 10: current fetch PC + 1.
- rx_data, input, 8: head byte of the UART RX FIFO; valid when rx_empty=0.
- rx_empty, input, 1: RX FIFO empty.
- rd, output, 1: one-cycle pop of the RX FIFO head.
- tx_data, output, 8: byte to transmit; valid when wr=1.
- tx_full, input, 1: TX FIFO full.
- wr, output, 1: push of tx_data into the TX FIFO.
- pipe_enable, output, 1: drives the pipeline enable.
- halted, output, 1: high once HALT_INSTR has been seen; sticky until reset.

Behaviour:
- Reset (reset_n=0 at a clock edge), including mid-RUN or mid-SEND:
  - state=IDLE.
  - pipe_enable, rd, wr and halted = 0.
  - cycle_count = 0; shift register = 0, so tx_data = 0.
  - Any partial frame is abandoned.
- Frame: 368 bits = 46 bytes, {cycle_count[31:0], 4'b0000, PC_plus_1[9:0], debug_signal[321:0]}.
  - Sent MSB byte first: byte 0 = cycle_count[31:24].
  - tx_data is always the top byte of the shift register.
- States:
  - IDLE: if rx_empty=0, rd=1 this cycle and rx_data is decoded in the same cycle.
    - CMD_STEP → STEP.
    - CMD_RUN → RUN.
    - CMD_DUMP → CAPTURE.
    - Any other byte, including CMD_PAUSE, is popped and discarded; stay in IDLE.
  - STEP: pipe_enable=1 for exactly one cycle; cycle_count+1 → CAPTURE.
  - RUN: pipe_enable=1 and cycle_count+1 every cycle. Leave for CAPTURE at the end of the cycle in which any of these holds:
    - debug_signal[321:290]==HALT_INSTR: sets halted=1; that cycle's enable is still counted.
    - cycle-in-run counter reaches MAX_CYCLES.
    - rx_empty=0 with rx_data==CMD_PAUSE: rd=1.
    - Non-pause RX bytes during RUN are left unread in the FIFO (rd=0).
  - CAPTURE: pipe_enable=0; load the frame into the shift register; byte_cnt=0 → SEND.
  - SEND: wr = !tx_full.
    - On each wr: shift left 8 and byte_cnt+1.
    - When the write of byte 45 is accepted → IDLE if halted=0, else HALTED.
    - tx_full=1 stalls indefinitely with no byte loss or duplication.
  - HALTED: pipe_enable stays 0.
    - CMD_DUMP → CAPTURE.
    - All other bytes are popped and discarded.
    - Only reset_n leaves HALTED.
- Invariants:
  - pipe_enable=1 only in STEP and RUN.
  - rd and wr are never high in the same cycle.
  - cycle_count wraps modulo 2^32.
  - The cycle-in-run counter clears on every entry to RUN.
- Simultaneous events in RUN: halt and pause in the same cycle → halt wins; halted=1 and pause is still popped.

Test Plan:
- Reset, then rx byte 8'h73 with tx_full=0:
  - Exactly 1 cycle of pipe_enable.
  - 46 consecutive wr pulses.
  - First four bytes 00 00 00 01; byte 4 = {4'b0, PC_plus_1[9:6]}.
- rx 8'h63, HALT_INSTR placed in debug_signal[321:290] on the 10th enabled cycle:
  - pipe_enable high exactly 10 cycles.
  - halted=1; frame count bytes 00 00 00 0A.
  - A following 8'h73 is discarded; 8'h64 re-sends an identical frame.
- MAX_CYCLES=16, rx 8'h63 with no halt → pipe_enable high 16 cycles, then dump with count 0x10, return to IDLE.
- RUN, then 8'h70 pushed after 5 cycles → RUN stops within 1 cycle of pause visibility, rd pulses once, dump follows.
- During SEND, hold tx_full=1 for 20 cycles after byte 10 → wr=0 throughout; resumed stream is bytes 10..45 with no gaps or repeats.
- reset_n=0 for 1 cycle mid-SEND (byte 20) and mid-RUN → all outputs 0 next cycle, state IDLE, cycle_count=0, halted=0.
